// File: rtl/lab4_vector_sequencer.sv
// Lab 4 input stage: produces the 4-bit decoder vector A in MANUAL, AUTO or PAUSE mode.
// Define LAB4_SEQ_DEBOUNCE_EN to insert the per-button debounce counters.
module lab4_vector_sequencer #(
  parameter int TICK_DIV  = 25000000,
  parameter int DB_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:3] sw,
  input  logic       btn_mode,
  input  logic       btn_run,
  input  logic       btn_step,
  output logic [0:3] A,
  output logic       a_valid,
  output logic       wrap,
  output logic [1:0] mode
);

  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    ST_MANUAL = 2'b00,
    ST_AUTO   = 2'b01,
    ST_PAUSE  = 2'b10
  } state_t;

  state_t        state_reg, state_next;
  logic [0:3]    sw_s1_reg, sw_s2_reg;
  logic [2:0]    btn_raw, btn_s1_reg, btn_s2_reg, btn_level, edge_reg, press;
  logic          mode_hit, run_hit, step_hit, incr;
  logic [0:3]    a_reg, a_next;
  logic          a_valid_reg, a_valid_next, wrap_reg, wrap_next;
  logic [PW-1:0] presc_reg, presc_next;

  // Bit order of the button bundle: [0]=mode, [1]=run, [2]=step.
  assign btn_raw = {btn_step, btn_run, btn_mode};

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1_reg  <= '0;
      sw_s2_reg  <= '0;
      btn_s1_reg <= '0;
      btn_s2_reg <= '0;
    end else begin
      sw_s1_reg  <= sw;
      sw_s2_reg  <= sw_s1_reg;
      btn_s1_reg <= btn_raw;
      btn_s2_reg <= btn_s1_reg;
    end
  end

`ifdef LAB4_SEQ_DEBOUNCE_EN
  localparam int DW = $clog2(DB_CYCLES);

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_db
      logic [DW-1:0] cnt_reg;
      logic          level_reg;

      // Any return to the accepted level restarts the stability count.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg   <= '0;
          level_reg <= 1'b0;
        end else if (btn_s2_reg[gi] != level_reg) begin
          if (cnt_reg == DW'(DB_CYCLES - 1)) begin
            level_reg <= btn_s2_reg[gi];
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + DW'(1);
          end
        end else begin
          cnt_reg <= '0;
        end
      end

      assign btn_level[gi] = level_reg;
    end
  endgenerate
`else
  assign btn_level = btn_s2_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) edge_reg <= '0;
    else     edge_reg <= btn_level;
  end

  assign press = btn_level & ~edge_reg;

  // Only the highest-priority press in a cycle acts: mode > run > step.
  assign mode_hit = press[0];
  assign run_hit  = press[1] & ~press[0];
  assign step_hit = press[2] & ~press[1] & ~press[0];

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_MANUAL;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_MANUAL: if (mode_hit) state_next = ST_AUTO;
      ST_AUTO: begin
        if (mode_hit)     state_next = ST_MANUAL;
        else if (run_hit) state_next = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (mode_hit)     state_next = ST_MANUAL;
        else if (run_hit) state_next = ST_AUTO;
      end
      default: state_next = ST_MANUAL;
    endcase
  end

  // Leaving a mode freezes A for that cycle; the prescaler only runs while staying in AUTO.
  always_comb begin
    a_next       = a_reg;
    a_valid_next = 1'b0;
    wrap_next    = 1'b0;
    presc_next   = '0;
    incr         = 1'b0;
    case (state_reg)
      ST_MANUAL: begin
        if (state_next == ST_MANUAL) begin
          a_next       = sw_s2_reg;
          a_valid_next = (sw_s2_reg != a_reg);
        end
      end
      ST_AUTO: begin
        if (state_next == ST_AUTO) begin
          if (presc_reg == PW'(TICK_DIV - 1)) incr = 1'b1;
          else                                presc_next = presc_reg + PW'(1);
        end
      end
      ST_PAUSE: incr = step_hit;
      default: ;
    endcase
    if (incr) begin
      a_next       = a_reg + 4'd1;
      a_valid_next = 1'b1;
      wrap_next    = (a_reg == 4'hF);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg       <= '0;
      a_valid_reg <= 1'b0;
      wrap_reg    <= 1'b0;
      presc_reg   <= '0;
    end else begin
      a_reg       <= a_next;
      a_valid_reg <= a_valid_next;
      wrap_reg    <= wrap_next;
      presc_reg   <= presc_next;
    end
  end

  assign A       = a_reg;
  assign a_valid = a_valid_reg;
  assign wrap    = wrap_reg;
  assign mode    = state_reg;

endmodule
